// File: rtl/mux_sel_rr_arbiter_pkg.sv
// rtl/mux_sel_rr_arbiter_pkg.sv - shared widths, state encoding and helpers for the mux arbiter
package mux_sel_rr_arbiter_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick4.sv
// rtl/mux_sel_rr_arbiter_rr_pick4.sv - combinational round-robin pick over four requests
module rr_pick4
  import mux_sel_rr_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the requester nearest the pointer wins last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// rtl/mux_sel_rr_arbiter.sv - round-robin owner arbiter driving a 4:1 mux select/enable
module mux_sel_rr_arbiter
  import mux_sel_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              done_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              enable_o,
  output logic [NUM_CH-1:0] grant_o,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              enable_q, enable_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              hold_expired;
  logic              owner_released;

  rr_pick4 u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // The owner is always the current select value while a grant is active.
  assign hold_expired   = (hold_q == HOLD_LAST);
  assign owner_released = done_i || !req_i[sel_q];

  // Next-state and registered-output decode; Sel only moves when a new grant starts.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    enable_d  = enable_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_valid) begin
          state_d  = ST_GRANT;
          sel_d    = pick_idx;
          grant_d  = onehot(pick_idx);
          enable_d = 1'b1;
          hold_d   = '0;
        end else begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          enable_d = 1'b0;
        end
      end

      ST_GRANT: begin
        if (owner_released || hold_expired) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          enable_d  = 1'b0;
          ptr_d     = sel_q + SEL_W'(1);
          timeout_d = hold_expired && !owner_released;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer, hold counter and output registers; reset clears outputs immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign sel_o     = sel_q;
  assign enable_o  = enable_q;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb/tb_mux_sel_rr_arbiter.sv - directed self-checking bench for mux_sel_rr_arbiter
module tb_mux_sel_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] grant;
  logic       timeout;
  logic       busy;

  int total;
  int bad;

  mux_sel_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .sel_o     (sel),
    .enable_o  (enable),
    .grant_o   (grant),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {sel, enable, grant, timeout, busy} against an expected tuple.
  task automatic chk(input string tag, input logic [1:0] e_sel, input logic e_en,
                     input logic [3:0] e_gnt, input logic e_to, input logic e_busy);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {sel, enable, grant, timeout, busy};
    exp = {e_sel, e_en, e_gnt, e_to, e_busy};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (sel,en,grant,to,busy)", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    total = 0;
    bad   = 0;

    // 1: reset with all requests high, then release with no requests
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    #1;
    chk("reset_async", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_held", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    req = 4'b0000;
    rst = 1'b0;
    tick();
    chk("idle_noreq_0", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("idle_noreq_1", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // 2: single requester ch2, Done in its third grant cycle
    req = 4'b0100;
    tick();
    chk("t2_grant_c1", 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
    tick();
    chk("t2_grant_c2", 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
    tick();
    chk("t2_grant_c3", 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
    done = 1'b1;
    tick();
    chk("t2_gap", 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk("t2_idle", 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0);

    // 3: all requesting, Done in each grant's 2nd cycle, pointer restarted at 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 4'b1111;
    exp_order[0] = 0;
    exp_order[1] = 1;
    exp_order[2] = 2;
    exp_order[3] = 3;
    exp_order[4] = 0;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("t3_g%0d_c1", g), 2'(exp_order[g]), 1'b1, 4'b0001 << exp_order[g], 1'b0, 1'b1);
      tick();
      chk($sformatf("t3_g%0d_c2", g), 2'(exp_order[g]), 1'b1, 4'b0001 << exp_order[g], 1'b0, 1'b1);
      done = 1'b1;
      tick();
      chk($sformatf("t3_g%0d_gap", g), 2'(exp_order[g]), 1'b0, 4'b0000, 1'b0, 1'b1);
      done = 1'b0;
    end
    req = 4'b0000;
    tick();
    chk("t3_idle", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // 4: ch0 held with no Done -> 8 grant cycles, timeout GAP, re-grant ch0
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("t4_hold_c%0d", c), 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1);
    end
    tick();
    chk("t4_timeout_gap", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    chk("t4_regrant", 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1);

    // 6a: Done coincides with the last allowed hold cycle -> no timeout
    for (int c = 1; c < 8; c++) begin
      tick();
      chk($sformatf("t6_hold_c%0d", c), 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1);
    end
    done = 1'b1;
    tick();
    chk("t6_done_at_max_gap", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
    done = 1'b0;
    tick();
    chk("t6_regrant", 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1);

    // 6b: owner drops its request -> release next cycle, no timeout
    req = 4'b0000;
    tick();
    chk("t6_reqdrop_gap", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("t6_reqdrop_idle", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Non-owner requests appearing mid-grant leave Sel untouched (pointer is 1)
    req = 4'b0010;
    tick();
    chk("nonowner_c1", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b1);
    req = 4'b1011;
    tick();
    chk("nonowner_c2", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b1);
    req = 4'b1001;
    tick();
    chk("nonowner_drop_gap", 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("next_pick_ch3", 2'd3, 1'b1, 4'b1000, 1'b0, 1'b1);

    // 5: async reset mid-grant on ch3, then pointer restarts from 0
    rst = 1'b1;
    #1;
    chk("t5_async_drop", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    chk("t5_after_reset_ch1", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk("t5_gap", 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("t5_idle", 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
